// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS multicycle controller and related decoders.
// Contents: opcode and ALU code constants, FSM state encoding, mux select
// encodings, ALU-decoder request class, and opcode classification helpers.
package mips_pkg;

  // Opcodes (instruction [31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_SLTIU = 6'b001011;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LB    = 6'b100000;
  localparam logic [5:0] OP_LH    = 6'b100001;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_LBU   = 6'b100100;
  localparam logic [5:0] OP_LHU   = 6'b100101;
  localparam logic [5:0] OP_LWU   = 6'b100111;
  localparam logic [5:0] OP_SB    = 6'b101000;
  localparam logic [5:0] OP_SH    = 6'b101001;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_HALT  = 6'b111111;

  // Funct-style ALU codes
  localparam logic [5:0] ALU_ADD  = 6'b100000;
  localparam logic [5:0] ALU_ADDU = 6'b100001;
  localparam logic [5:0] ALU_SUB  = 6'b100010;
  localparam logic [5:0] ALU_AND  = 6'b100100;
  localparam logic [5:0] ALU_OR   = 6'b100101;
  localparam logic [5:0] ALU_XOR  = 6'b100110;
  localparam logic [5:0] ALU_SLT  = 6'b101010;
  localparam logic [5:0] ALU_SLTU = 6'b101011;
  localparam logic [5:0] ALU_LUI  = 6'b001111;

  // FSM state encoding
  localparam logic [3:0] S_RST     = 4'd0;
  localparam logic [3:0] S_FETCH   = 4'd1;
  localparam logic [3:0] S_DECODE  = 4'd2;
  localparam logic [3:0] S_MEM_ADR = 4'd3;
  localparam logic [3:0] S_MEM_RD  = 4'd4;
  localparam logic [3:0] S_MEM_WB  = 4'd5;
  localparam logic [3:0] S_MEM_WR  = 4'd6;
  localparam logic [3:0] S_R_EXEC  = 4'd7;
  localparam logic [3:0] S_I_EXEC  = 4'd8;
  localparam logic [3:0] S_ALU_WB  = 4'd9;
  localparam logic [3:0] S_BRANCH  = 4'd10;
  localparam logic [3:0] S_JUMP    = 4'd11;
  localparam logic [3:0] S_HALT    = 4'd12;
  localparam logic [3:0] S_FAULT   = 4'd13;

  // alu_src_b select
  localparam logic [1:0] SRCB_REGB  = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  // pc_src select
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // What the ALU is being asked to do this cycle
  typedef enum logic [2:0] {
    ALU_CLS_NONE,
    ALU_CLS_ADD,
    ALU_CLS_FUNCT,
    ALU_CLS_IMM,
    ALU_CLS_SUB
  } alu_class_t;

  function automatic logic is_store(input logic [5:0] op);
    return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
  endfunction

  // DECODE dispatch target; unknown opcodes land in S_FAULT
  function automatic logic [3:0] dispatch_state(input logic [5:0] op);
    logic [3:0] nxt;
    case (op)
      OP_RTYPE:                                   nxt = S_R_EXEC;
      OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW, OP_LWU,
      OP_SB, OP_SH, OP_SW:                        nxt = S_MEM_ADR;
      OP_ADDI, OP_ADDIU, OP_ANDI, OP_ORI, OP_XORI,
      OP_SLTI, OP_SLTIU, OP_LUI:                  nxt = S_I_EXEC;
      OP_BEQ, OP_BNE:                             nxt = S_BRANCH;
      OP_J:                                       nxt = S_JUMP;
      OP_HALT:                                    nxt = S_HALT;
      default:                                    nxt = S_FAULT;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/mc_alu_decoder.sv
// Combinational ALU control decoder.
// Ports: alu_class (request class from the sequencer), op/funct (current
// instruction fields) -> alu_control (funct-style ALU operation code).
module mc_alu_decoder
  import mips_pkg::*;
(
  input  alu_class_t  alu_class,
  input  logic [5:0]  op,
  input  logic [5:0]  funct,
  output logic [5:0]  alu_control
);

  always_comb begin
    alu_control = 6'b000000;
    case (alu_class)
      ALU_CLS_ADD:   alu_control = ALU_ADD;
      ALU_CLS_SUB:   alu_control = ALU_SUB;
      ALU_CLS_FUNCT: alu_control = funct;
      ALU_CLS_IMM: begin
        case (op)
          OP_ADDI:  alu_control = ALU_ADD;
          OP_ADDIU: alu_control = ALU_ADDU;
          OP_ANDI:  alu_control = ALU_AND;
          OP_ORI:   alu_control = ALU_OR;
          OP_XORI:  alu_control = ALU_XOR;
          OP_SLTI:  alu_control = ALU_SLT;
          OP_SLTIU: alu_control = ALU_SLTU;
          OP_LUI:   alu_control = ALU_LUI;
          default:  alu_control = ALU_ADD;
        endcase
      end
      default:       alu_control = 6'b000000;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle sequencer for the MIPS core.
// Inputs: clk, reset (async, active-high), op/funct from IR, ALU zero flag,
// mem_ready handshake. Outputs: datapath strobes/selects, current state,
// retired-instruction count and sticky halted/illegal_op/mem_timeout flags.
//
// state    | meaning
// RST      | post-reset idle, all strobes off
// FETCH    | read instruction at PC, PC+4 on ready
// DECODE   | compute branch target into ALUOut, dispatch
// MEM_ADR  | base + offset address for load/store
// MEM_RD   | data read, wait for ready
// MEM_WB   | load data into rt
// MEM_WR   | data write, wait for ready
// R_EXEC   | register-register ALU op
// I_EXEC   | register-immediate ALU op
// ALU_WB   | ALU result into rd (R-type) or rt (I-type)
// BRANCH   | compare, conditional PC load from ALUOut
// JUMP     | PC load from jump target
// HALT     | stopped by halt opcode
// FAULT    | illegal opcode or memory timeout
module mips_multicycle_ctrl
  import mips_pkg::*;
#(
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       op,
  input  logic [5:0]       funct,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             iord,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             pc_en,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             reg_write,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [5:0]       alu_control,
  output logic [1:0]       pc_src,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] instr_count,
  output logic             halted,
  output logic             illegal_op,
  output logic             mem_timeout
);

  // Counter only needs to reach TIMEOUT-1: the TIMEOUT-th idle cycle is the
  // one that still has the final chance to see mem_ready.
  localparam int WAIT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(TIMEOUT - 1);
  localparam bit TIMEOUT_EN = (TIMEOUT != 0);

  logic [3:0]        next_state;
  logic [WAIT_W-1:0] wait_cnt;
  logic              wait_state;
  logic              wait_expired;
  logic              timeout_hit;
  logic              illegal_hit;
  logic              retire;
  alu_class_t        alu_class;

  assign wait_state   = (state == S_FETCH) || (state == S_MEM_RD) || (state == S_MEM_WR);
  assign wait_expired = TIMEOUT_EN && !mem_ready && (wait_cnt == WAIT_LIMIT);

  always_comb begin
    next_state  = state;
    timeout_hit = 1'b0;
    illegal_hit = 1'b0;
    case (state)
      S_RST:     next_state = S_FETCH;
      S_FETCH: begin
        if (mem_ready)         next_state = S_DECODE;
        else if (wait_expired) begin
          next_state  = S_FAULT;
          timeout_hit = 1'b1;
        end
      end
      S_DECODE: begin
        next_state  = dispatch_state(op);
        illegal_hit = (next_state == S_FAULT);
      end
      S_MEM_ADR: next_state = is_store(op) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD: begin
        if (mem_ready)         next_state = S_MEM_WB;
        else if (wait_expired) begin
          next_state  = S_FAULT;
          timeout_hit = 1'b1;
        end
      end
      S_MEM_WB:  next_state = S_FETCH;
      S_MEM_WR: begin
        if (mem_ready)         next_state = S_FETCH;
        else if (wait_expired) begin
          next_state  = S_FAULT;
          timeout_hit = 1'b1;
        end
      end
      S_R_EXEC:  next_state = S_ALU_WB;
      S_I_EXEC:  next_state = S_ALU_WB;
      S_ALU_WB:  next_state = S_FETCH;
      S_BRANCH:  next_state = S_FETCH;
      S_JUMP:    next_state = S_FETCH;
      S_HALT:    next_state = S_HALT;
      S_FAULT:   next_state = S_FAULT;
      default:   next_state = S_FAULT;
    endcase
  end

  // The FETCH after RST is the first fetch, not a retirement.
  assign retire = ((next_state == S_FETCH) && (state != S_FETCH) && (state != S_RST)) ||
                  ((next_state == S_HALT) && (state != S_HALT));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_RST;
      wait_cnt    <= '0;
      instr_count <= '0;
      halted      <= 1'b0;
      illegal_op  <= 1'b0;
      mem_timeout <= 1'b0;
    end else begin
      state <= next_state;
      if (wait_state && !mem_ready && (next_state == state))
        wait_cnt <= wait_cnt + 1'b1;
      else
        wait_cnt <= '0;
      if (retire)
        instr_count <= instr_count + CNT_W'(1);
      if (next_state == S_HALT) halted <= 1'b1;
      if (illegal_hit)          illegal_op <= 1'b1;
      if (timeout_hit)          mem_timeout <= 1'b1;
    end
  end

  always_comb begin
    iord       = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    pc_en      = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_REGB;
    pc_src     = PCSRC_ALU;
    alu_class  = ALU_CLS_NONE;
    case (state)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = SRCB_FOUR;
        alu_class = ALU_CLS_ADD;
        ir_write  = mem_ready;
        pc_en     = mem_ready;
      end
      S_DECODE: begin
        alu_src_b = SRCB_IMMSH;
        alu_class = ALU_CLS_ADD;
      end
      S_MEM_ADR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        alu_class = ALU_CLS_ADD;
      end
      S_MEM_RD: begin
        iord     = 1'b1;
        mem_read = 1'b1;
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_MEM_WR: begin
        iord      = 1'b1;
        mem_write = 1'b1;
      end
      S_R_EXEC: begin
        alu_src_a = 1'b1;
        alu_class = ALU_CLS_FUNCT;
      end
      S_I_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        alu_class = ALU_CLS_IMM;
      end
      S_ALU_WB: begin
        reg_write = 1'b1;
        reg_dst   = (op == OP_RTYPE);
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_class = ALU_CLS_SUB;
        pc_src    = PCSRC_ALUOUT;
        pc_en     = (op == OP_BNE) ? ~zero : zero;
      end
      S_JUMP: begin
        pc_src = PCSRC_JUMP;
        pc_en  = 1'b1;
      end
      default: ;
    endcase
  end

  mc_alu_decoder u_alu_decoder (
    .alu_class   (alu_class),
    .op          (op),
    .funct       (funct),
    .alu_control (alu_control)
  );

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
module tb_mips_multicycle_ctrl;

  localparam logic [3:0] ST_RST = 4'd0, ST_FETCH = 4'd1, ST_DECODE = 4'd2, ST_MEM_ADR = 4'd3,
                         ST_MEM_RD = 4'd4, ST_MEM_WB = 4'd5, ST_MEM_WR = 4'd6, ST_R_EXEC = 4'd7,
                         ST_I_EXEC = 4'd8, ST_ALU_WB = 4'd9, ST_BRANCH = 4'd10, ST_JUMP = 4'd11,
                         ST_HALT = 4'd12, ST_FAULT = 4'd13;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  op, funct;
  logic        zero, mem_ready;
  logic        iord, mem_read, mem_write, ir_write, pc_en;
  logic        reg_dst, mem_to_reg, reg_write, alu_src_a;
  logic [1:0]  alu_src_b, pc_src;
  logic [5:0]  alu_control;
  logic [3:0]  state;
  logic [31:0] instr_count;
  logic        halted, illegal_op, mem_timeout;

  mips_multicycle_ctrl #(.CNT_W(32), .TIMEOUT(4)) dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
    .iord(iord), .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write), .pc_en(pc_en),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_control(alu_control), .pc_src(pc_src), .state(state),
    .instr_count(instr_count), .halted(halted), .illegal_op(illegal_op), .mem_timeout(mem_timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rdy;
    logic        zro;
    logic [5:0]  op;
    logic [5:0]  fn;
    logic [3:0]  st;
    logic [18:0] ctl;
    logic [31:0] cnt;
    logic [2:0]  flg;  // {halted, illegal_op, mem_timeout}
  } step_t;

  step_t sb[$];
  int checks = 0;
  int failures = 0;

  logic [18:0] obs_ctl;
  assign obs_ctl = {iord, mem_read, mem_write, ir_write, pc_en, reg_dst, mem_to_reg, reg_write,
                    alu_src_a, alu_src_b, alu_control, pc_src};

  // ctl packing: iord,mem_read,mem_write,ir_write,pc_en,reg_dst,mem_to_reg,reg_write,alu_src_a,alu_src_b,alu_control,pc_src
  function automatic logic [18:0] mk(input logic io, mr, mw, irw, pce, rd, m2r, rw, asa,
                                     input logic [1:0] asb, input logic [5:0] alu, input logic [1:0] pcs);
    return {io, mr, mw, irw, pce, rd, m2r, rw, asa, asb, alu, pcs};
  endfunction

  localparam logic [5:0] ADD = 6'b100000;
  localparam logic [18:0] C_OFF = 19'd0;

  function automatic logic [18:0] c_fetch(input logic r);
    return mk(0, 1, 0, r, r, 0, 0, 0, 0, 2'b01, ADD, 2'b00);
  endfunction

  localparam logic [18:0] C_DEC    = {9'b0, 2'b11, 6'b100000, 2'b00};
  localparam logic [18:0] C_MADR   = {8'b0, 1'b1, 2'b10, 6'b100000, 2'b00};
  localparam logic [18:0] C_MRD    = {1'b1, 1'b1, 17'b0};
  localparam logic [18:0] C_MWB    = {6'b0, 1'b1, 1'b1, 11'b0};
  localparam logic [18:0] C_MWR    = {1'b1, 1'b0, 1'b1, 16'b0};

  task automatic push(input logic rdy, zro, input logic [5:0] o, f, input logic [3:0] st,
                      input logic [18:0] ctl, input logic [31:0] cnt, input logic [2:0] flg);
    step_t s;
    s.rdy = rdy; s.zro = zro; s.op = o; s.fn = f; s.st = st; s.ctl = ctl; s.cnt = cnt; s.flg = flg;
    sb.push_back(s);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h t=%0t", tag, obs, exp, $time);
    end
  endtask

  // Called at posedge+1: drive each step's inputs, compare mid-cycle, advance.
  task automatic run_queue();
    step_t s;
    while (sb.size() > 0) begin
      s = sb.pop_front();
      mem_ready = s.rdy; zero = s.zro; op = s.op; funct = s.fn;
      @(negedge clk);
      chk("state", {28'd0, state}, {28'd0, s.st});
      chk("ctl", {13'd0, obs_ctl}, {13'd0, s.ctl});
      chk("instr_count", instr_count, s.cnt);
      chk("flags", {29'd0, halted, illegal_op, mem_timeout}, {29'd0, s.flg});
      @(posedge clk); #1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    chk("rst_state", {28'd0, state}, {28'd0, ST_RST});
    chk("rst_ctl", {13'd0, obs_ctl}, 32'd0);
    chk("rst_count", instr_count, 32'd0);
    chk("rst_flags", {29'd0, halted, illegal_op, mem_timeout}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; op = '0; funct = '0; zero = 1'b0; mem_ready = 1'b0;
    @(posedge clk); #1;
    do_reset();

    // R-type ADD
    push(1, 0, 6'b000000, ADD, ST_RST,    C_OFF, 0, 3'b000);
    push(1, 0, 6'b000000, ADD, ST_FETCH,  c_fetch(1), 0, 3'b000);
    push(1, 0, 6'b000000, ADD, ST_DECODE, C_DEC, 0, 3'b000);
    push(1, 0, 6'b000000, ADD, ST_R_EXEC, mk(0,0,0,0,0,0,0,0,1,2'b00,ADD,2'b00), 0, 3'b000);
    push(1, 0, 6'b000000, ADD, ST_ALU_WB, mk(0,0,0,0,0,1,0,1,0,2'b00,6'd0,2'b00), 0, 3'b000);
    // LW with three idle cycles in MEM_RD
    push(1, 0, 6'b100011, 6'd0, ST_FETCH,   c_fetch(1), 1, 3'b000);
    push(1, 0, 6'b100011, 6'd0, ST_DECODE,  C_DEC, 1, 3'b000);
    push(1, 0, 6'b100011, 6'd0, ST_MEM_ADR, C_MADR, 1, 3'b000);
    for (int i = 0; i < 3; i++)
      push(0, 0, 6'b100011, 6'd0, ST_MEM_RD, C_MRD, 1, 3'b000);
    push(1, 0, 6'b100011, 6'd0, ST_MEM_RD,  C_MRD, 1, 3'b000);
    push(1, 0, 6'b100011, 6'd0, ST_MEM_WB,  C_MWB, 1, 3'b000);
    // BNE with zero=1: not taken
    push(1, 1, 6'b000101, 6'd0, ST_FETCH,  c_fetch(1), 2, 3'b000);
    push(1, 1, 6'b000101, 6'd0, ST_DECODE, C_DEC, 2, 3'b000);
    push(1, 1, 6'b000101, 6'd0, ST_BRANCH, mk(0,0,0,0,0,0,0,0,1,2'b00,6'b100010,2'b01), 2, 3'b000);
    // BEQ with zero=1: taken
    push(1, 1, 6'b000100, 6'd0, ST_FETCH,  c_fetch(1), 3, 3'b000);
    push(1, 1, 6'b000100, 6'd0, ST_DECODE, C_DEC, 3, 3'b000);
    push(1, 1, 6'b000100, 6'd0, ST_BRANCH, mk(0,0,0,0,1,0,0,0,1,2'b00,6'b100010,2'b01), 3, 3'b000);
    // SW
    push(1, 0, 6'b101011, 6'd0, ST_FETCH,   c_fetch(1), 4, 3'b000);
    push(1, 0, 6'b101011, 6'd0, ST_DECODE,  C_DEC, 4, 3'b000);
    push(1, 0, 6'b101011, 6'd0, ST_MEM_ADR, C_MADR, 4, 3'b000);
    push(1, 0, 6'b101011, 6'd0, ST_MEM_WR,  C_MWR, 4, 3'b000);
    // SLTIU
    push(1, 0, 6'b001011, 6'd0, ST_FETCH,   c_fetch(1), 5, 3'b000);
    push(1, 0, 6'b001011, 6'd0, ST_DECODE,  C_DEC, 5, 3'b000);
    push(1, 0, 6'b001011, 6'd0, ST_I_EXEC,  mk(0,0,0,0,0,0,0,0,1,2'b10,6'b101011,2'b00), 5, 3'b000);
    push(1, 0, 6'b001011, 6'd0, ST_ALU_WB,  mk(0,0,0,0,0,0,0,1,0,2'b00,6'd0,2'b00), 5, 3'b000);
    // J
    push(1, 0, 6'b000010, 6'd0, ST_FETCH,  c_fetch(1), 6, 3'b000);
    push(1, 0, 6'b000010, 6'd0, ST_DECODE, C_DEC, 6, 3'b000);
    push(1, 0, 6'b000010, 6'd0, ST_JUMP,   mk(0,0,0,0,1,0,0,0,0,2'b00,6'd0,2'b10), 6, 3'b000);
    // ORI whose fetch gets ready on the last allowed cycle
    for (int i = 0; i < 3; i++)
      push(0, 0, 6'b001101, 6'd0, ST_FETCH, c_fetch(0), 7, 3'b000);
    push(1, 0, 6'b001101, 6'd0, ST_FETCH,   c_fetch(1), 7, 3'b000);
    push(1, 0, 6'b001101, 6'd0, ST_DECODE,  C_DEC, 7, 3'b000);
    push(1, 0, 6'b001101, 6'd0, ST_I_EXEC,  mk(0,0,0,0,0,0,0,0,1,2'b10,6'b100101,2'b00), 7, 3'b000);
    push(1, 0, 6'b001101, 6'd0, ST_ALU_WB,  mk(0,0,0,0,0,0,0,1,0,2'b00,6'd0,2'b00), 7, 3'b000);
    // Illegal opcode
    push(1, 0, 6'b010011, 6'd0, ST_FETCH,  c_fetch(1), 8, 3'b000);
    push(1, 0, 6'b010011, 6'd0, ST_DECODE, C_DEC, 8, 3'b000);
    push(1, 0, 6'b010011, 6'd0, ST_FAULT,  C_OFF, 8, 3'b010);
    push(1, 0, 6'b010011, 6'd0, ST_FAULT,  C_OFF, 8, 3'b010);
    run_queue();
    do_reset();

    // HALT
    push(1, 0, 6'b111111, 6'd0, ST_RST,    C_OFF, 0, 3'b000);
    push(1, 0, 6'b111111, 6'd0, ST_FETCH,  c_fetch(1), 0, 3'b000);
    push(1, 0, 6'b111111, 6'd0, ST_DECODE, C_DEC, 0, 3'b000);
    push(1, 0, 6'b111111, 6'd0, ST_HALT,   C_OFF, 1, 3'b100);
    push(1, 0, 6'b111111, 6'd0, ST_HALT,   C_OFF, 1, 3'b100);
    run_queue();
    do_reset();

    // Reset during a pending store must drop strobes immediately and retire nothing
    push(1, 0, 6'b101011, 6'd0, ST_RST,     C_OFF, 0, 3'b000);
    push(1, 0, 6'b101011, 6'd0, ST_FETCH,   c_fetch(1), 0, 3'b000);
    push(1, 0, 6'b101011, 6'd0, ST_DECODE,  C_DEC, 0, 3'b000);
    push(1, 0, 6'b101011, 6'd0, ST_MEM_ADR, C_MADR, 0, 3'b000);
    push(0, 0, 6'b101011, 6'd0, ST_MEM_WR,  C_MWR, 0, 3'b000);
    run_queue();
    mem_ready = 1'b0;
    @(negedge clk);
    chk("abort_pre_write", {31'd0, mem_write}, 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("abort_write", {31'd0, mem_write}, 32'd0);
    chk("abort_iord", {31'd0, iord}, 32'd0);
    chk("abort_state", {28'd0, state}, {28'd0, ST_RST});
    chk("abort_count", instr_count, 32'd0);
    @(posedge clk); #1;
    do_reset();

    // Fetch timeout
    push(0, 0, 6'd0, 6'd0, ST_RST, C_OFF, 0, 3'b000);
    for (int i = 0; i < 4; i++)
      push(0, 0, 6'd0, 6'd0, ST_FETCH, c_fetch(0), 0, 3'b000);
    push(0, 0, 6'd0, 6'd0, ST_FAULT, C_OFF, 0, 3'b001);
    push(1, 0, 6'd0, 6'd0, ST_FAULT, C_OFF, 0, 3'b001);
    run_queue();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
